// File: rtl/net_arb_pkg.sv
// Shared sizing helpers for the output-port arbiter, following the vc-net-msgs
// layout {dest, src, opaque, payload} with dest in the most significant bits.
package net_arb_pkg;

  function automatic int vc_net_msg_nbits(input int p, input int o, input int s);
    return p + o + 2 * s;
  endfunction

  function automatic int arb_ptr_nbits(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int vc_net_msg_dest_lsb(input int p, input int o, input int s);
    return p + o + s;
  endfunction

endpackage

// File: rtl/net_out_port_arbiter_if.sv
// Request side (val/rdy/msg per input channel) and the single output port of
// one arbiter instance. The arbiter takes the slave view.
interface net_out_port_arbiter_if
  import net_arb_pkg::*;
#(
  parameter int p_num_ports = 4,
  parameter int p_msg_nbits = vc_net_msg_nbits(8, 8, 2)
);
  logic [p_num_ports-1:0]             in_val;
  logic [p_num_ports-1:0]             in_rdy;
  logic [p_num_ports*p_msg_nbits-1:0] in_msg;
  logic                               out_val;
  logic                               out_rdy;
  logic [p_msg_nbits-1:0]             out_msg;

  modport master (
    output in_val, in_msg, out_rdy,
    input  in_rdy, out_val, out_msg
  );

  modport slave (
    input  in_val, in_msg, out_rdy,
    output in_rdy, out_val, out_msg
  );
endinterface

// File: rtl/net_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after rr_ptr and
// moves the pointer just past the winner whenever the grant is consumed.
module net_rr_arb
  import net_arb_pkg::*;
#(
  parameter int p_num_ports = 4,
  localparam int c_ptr_nbits = arb_ptr_nbits(p_num_ports)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [p_num_ports-1:0] req,
  input  logic                   en,
  output logic [p_num_ports-1:0] grant,
  output logic [c_ptr_nbits-1:0] grant_idx
);

  logic [c_ptr_nbits-1:0] rr_ptr;
  logic                   found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 0; k < p_num_ports; k++) begin
      int sum;
      sum = int'(rr_ptr) + k;
      if (sum >= p_num_ports) sum = sum - p_num_ports;
      if (!found && req[sum]) begin
        found      = 1'b1;
        grant[sum] = 1'b1;
        grant_idx  = c_ptr_nbits'(sum);
      end
    end
  end

  // Pointer only advances when a grant is actually taken, so stalls freeze it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (en && (|grant)) begin
      rr_ptr <= (grant_idx == c_ptr_nbits'(p_num_ports - 1)) ? '0
                                                             : grant_idx + c_ptr_nbits'(1);
    end
  end

endmodule

// File: rtl/net_out_port_arbiter.sv
// Shares one network output port among p_num_ports input channels with
// round-robin arbitration and a single registered output stage.
module net_out_port_arbiter
  import net_arb_pkg::*;
#(
  parameter int p_num_ports     = 4,
  parameter int p_payload_nbits = 8,
  parameter int p_opaque_nbits  = 8,
  parameter int p_srcdest_nbits = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  net_out_port_arbiter_if.slave    port,
  output logic [15:0]              xfer_count
);

  localparam int c_msg_nbits = vc_net_msg_nbits(p_payload_nbits, p_opaque_nbits, p_srcdest_nbits);
  localparam int c_ptr_nbits = arb_ptr_nbits(p_num_ports);

  logic                   can_load;
  logic                   arb_en;
  logic                   in_fire;
  logic                   out_fire;
  logic [p_num_ports-1:0] grant;
  logic [c_ptr_nbits-1:0] grant_idx;
  logic [c_msg_nbits-1:0] grant_msg;

  // The register may take a new message when empty or when it drains this cycle.
  assign can_load     = !port.out_val || port.out_rdy;
  assign arb_en       = can_load && reset;
  assign port.in_rdy  = grant & {p_num_ports{arb_en}};
  assign in_fire      = |(port.in_rdy & port.in_val);
  assign out_fire     = port.out_val && port.out_rdy;
  assign grant_msg    = port.in_msg[int'(grant_idx)*c_msg_nbits +: c_msg_nbits];

  net_rr_arb #(
    .p_num_ports (p_num_ports)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (port.in_val),
    .en        (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      port.out_val <= 1'b0;
      port.out_msg <= '0;
      xfer_count   <= '0;
    end else begin
      if (in_fire) begin
        port.out_msg <= grant_msg;
        port.out_val <= 1'b1;
      end else if (out_fire) begin
        port.out_val <= 1'b0;
      end
      if (out_fire) xfer_count <= xfer_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_net_out_port_arbiter.sv
// Scoreboard bench: directed vectors on one arbiter, then a 4-port network of
// arbiters with random-delay sources and unordered sinks.
module tb_net_out_port_arbiter;
  import net_arb_pkg::*;

  localparam int N = 4;
  localparam int P = 8;
  localparam int O = 8;
  localparam int S = 2;
  localparam int M = vc_net_msg_nbits(P, O, S);

  typedef logic [M-1:0] msg_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Single arbiter under directed test
  logic [N-1:0]   force_val    = '0;
  logic [N-1:0]   src_vld      = '0;
  logic [N*M-1:0] drv_msg      = '0;
  logic           main_out_rdy = 1'b1;
  logic [15:0]    main_xfer;
  msg_t           src_q[N][$];
  msg_t           exp_q[$];

  net_out_port_arbiter_if #(.p_num_ports(N), .p_msg_nbits(M)) dif ();
  assign dif.in_val  = force_val | src_vld;
  assign dif.in_msg  = drv_msg;
  assign dif.out_rdy = main_out_rdy;

  net_out_port_arbiter #(
    .p_num_ports(N), .p_payload_nbits(P), .p_opaque_nbits(O), .p_srcdest_nbits(S)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .port       (dif),
    .xfer_count (main_xfer)
  );

  // Four-port network for the random test
  logic [N-1:0]   net_in_val[N];
  logic [N-1:0]   net_in_rdy[N];
  logic [N*M-1:0] net_in_msg;
  logic           net_out_val[N];
  logic           net_out_rdy[N];
  msg_t           net_out_msg[N];
  logic [15:0]    net_xfer[N];
  logic [N-1:0]   nsrc_val = '0;
  logic [N-1:0]   nsrc_rdy;
  msg_t           nsrc_msg[N] = '{default: '0};
  int             pend[msg_t];

  always_comb begin
    for (int d = 0; d < N; d++) net_in_val[d] = '0;
    for (int s = 0; s < N; s++) net_in_val[int'(nsrc_msg[s][M-1 -: S])][s] = nsrc_val[s];
  end

  always_comb begin
    nsrc_rdy = '0;
    for (int s = 0; s < N; s++) nsrc_rdy[s] = net_in_rdy[int'(nsrc_msg[s][M-1 -: S])][s];
  end

  always_comb begin
    net_in_msg = '0;
    for (int s = 0; s < N; s++) net_in_msg[s*M +: M] = nsrc_msg[s];
  end

  for (genvar g = 0; g < N; g++) begin : g_net
    net_out_port_arbiter_if #(.p_num_ports(N), .p_msg_nbits(M)) nif ();
    assign nif.in_val      = net_in_val[g];
    assign nif.in_msg      = net_in_msg;
    assign nif.out_rdy     = net_out_rdy[g];
    assign net_in_rdy[g]   = nif.in_rdy;
    assign net_out_val[g]  = nif.out_val;
    assign net_out_msg[g]  = nif.out_msg;

    net_out_port_arbiter #(
      .p_num_ports(N), .p_payload_nbits(P), .p_opaque_nbits(O), .p_srcdest_nbits(S)
    ) u_port (
      .clk        (clk),
      .reset      (reset),
      .port       (nif),
      .xfer_count (net_xfer[g])
    );
  end

  function automatic msg_t mk(input logic [S-1:0] dest, input logic [S-1:0] src,
                              input logic [O-1:0] opq, input logic [P-1:0] pay);
    return {dest, src, opq, pay};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int p, input msg_t m, input bit expect_out);
    src_q[p].push_back(m);
    if (expect_out) exp_q.push_back(m);
  endtask

  // Sources hold each message until its in-fire, then present the next one.
  initial begin
    forever begin
      logic [N-1:0] fire;
      @(negedge clk);
      fire = dif.in_val & dif.in_rdy;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          src_vld[i]         = 1'b1;
          drv_msg[i*M +: M]  = src_q[i][0];
        end else begin
          src_vld[i]         = 1'b0;
          drv_msg[i*M +: M]  = '0;
        end
      end
    end
  end

  // Monitor: every out fire must match the head of the expected queue.
  always @(negedge clk) begin
    if (reset && dif.out_val && dif.out_rdy) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL out_unexpected: got %0h expected nothing", dif.out_msg);
      end else begin
        checkOutput("out_msg", dif.out_msg, exp_q.pop_front());
      end
    end
  end

  task automatic waitDrain(input string name, input int limit);
    int c = 0;
    while (exp_q.size() != 0 && c < limit) begin
      @(negedge clk);
      #2;
      c++;
    end
    checkOutput({name, "_drain"}, exp_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic waitOutVal(input string name, input int limit);
    int c = 0;
    while (!dif.out_val && c < limit) begin
      @(negedge clk);
      c++;
    end
    if (!dif.out_val) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_timeout: got out_val=0 expected out_val=1", name);
    end
  endtask

  task automatic runNet(input string name, input int sd, input int kd, input int nmsg);
    int   remaining[N];
    int   cd[N];
    int   seq[N];
    logic [N-1:0] fired;
    int   sent, delivered, cyc, xsum;
    msg_t m;
    logic ok;
    @(negedge clk);
    reset    = 1'b0;
    nsrc_val = '0;
    for (int d = 0; d < N; d++) net_out_rdy[d] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int s = 0; s < N; s++) begin
      remaining[s] = nmsg;
      cd[s]        = 0;
      seq[s]       = 0;
    end
    pend.delete();
    sent = 0; delivered = 0; cyc = 0;
    while (delivered < N * nmsg && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      for (int d = 0; d < N; d++) begin
        if (net_out_val[d] && net_out_rdy[d]) begin
          m  = net_out_msg[d];
          ok = pend.exists(m) && (int'(m[M-1 -: S]) == d);
          checkOutput({name, "_deliver"}, ok, 1'b1);
          if (pend.exists(m)) pend.delete(m);
          delivered++;
        end
      end
      fired = nsrc_val & nsrc_rdy;
      @(posedge clk);
      #1;
      for (int s = 0; s < N; s++) begin
        if (fired[s]) begin
          nsrc_val[s] = 1'b0;
          cd[s]       = $urandom_range(0, sd);
        end
        if (!nsrc_val[s]) begin
          if (cd[s] > 0) begin
            cd[s]--;
          end else if (remaining[s] > 0) begin
            m = mk(S'($urandom_range(0, N - 1)), S'(s), O'(seq[s]), P'($urandom()));
            pend[m]     = 1;
            nsrc_msg[s] = m;
            nsrc_val[s] = 1'b1;
            remaining[s]--;
            seq[s]++;
            sent++;
          end
        end
      end
      for (int d = 0; d < N; d++)
        net_out_rdy[d] = (kd == 0) ? 1'b1 : ($urandom_range(0, kd) == 0);
    end
    xsum = 0;
    for (int d = 0; d < N; d++) xsum += int'(net_xfer[d]);
    checkOutput({name, "_count"}, delivered, N * nmsg);
    checkOutput({name, "_pending"}, pend.size(), 0);
    checkOutput({name, "_xfer_sum"}, xsum, N * nmsg);
    nsrc_val = '0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    msg_t m2, m5a, m5b, m4a, m4b, m7;
    for (int d = 0; d < N; d++) net_out_rdy[d] = 1'b0;

    // Reset held with every input requesting
    force_val = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_rdy", dif.in_rdy, 4'h0);
    checkOutput("rst_out_val", dif.out_val, 1'b0);
    checkOutput("rst_out_msg", dif.out_msg, '0);
    checkOutput("rst_xfer", main_xfer, 16'd0);
    force_val = '0;
    reset     = 1'b1;

    // Single requester on port 2
    m2 = mk(2'd1, 2'd2, 8'h05, 8'hfe);
    applyStimulus(2, m2, 1'b1);
    waitDrain("single", 10);
    checkOutput("single_rr_ptr", u_dut.u_arb.rr_ptr, 2'd3);

    // Pointer at 3 with ports 0 and 3 requesting: 3 wins, then 0
    m5a = mk(2'd0, 2'd0, 8'h50, 8'ha0);
    m5b = mk(2'd3, 2'd3, 8'h53, 8'ha3);
    applyStimulus(3, m5b, 1'b1);
    applyStimulus(0, m5a, 1'b1);
    waitDrain("wrap", 10);
    checkOutput("wrap_rr_ptr", u_dut.u_arb.rr_ptr, 2'd1);

    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checkOutput("pulse_rr_ptr", u_dut.u_arb.rr_ptr, 2'd0);
    checkOutput("pulse_xfer", main_xfer, 16'd0);

    // All four continuously valid: order 0,1,2,3,0,1,2,3 at one per cycle
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < N; p++)
        applyStimulus(p, mk(S'(r), S'(p), O'(8'h30 + r), O'(8'hc0 + p)), 1'b1);
    waitOutVal("rate", 10);
    repeat (7) @(negedge clk);
    #2;
    checkOutput("rate_no_bubble", exp_q.size(), 0);
    waitDrain("rate", 10);

    // Backpressure for 5 cycles with a message held
    main_out_rdy = 1'b0;
    m4a = mk(2'd2, 2'd1, 8'h41, 8'h11);
    m4b = mk(2'd3, 2'd2, 8'h42, 8'h22);
    applyStimulus(1, m4a, 1'b1);
    applyStimulus(2, m4b, 1'b1);
    waitOutVal("stall", 10);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("stall_out_msg", dif.out_msg, m4a);
      checkOutput("stall_in_rdy", dif.in_rdy, 4'h0);
    end
    main_out_rdy = 1'b1;
    waitDrain("stall", 10);
    checkOutput("xfer_total", main_xfer, 16'd10);

    // Reset while a message sits in the output register drops it
    main_out_rdy = 1'b0;
    m7 = mk(2'd1, 2'd0, 8'h77, 8'h70);
    applyStimulus(0, m7, 1'b0);
    waitOutVal("midrst", 10);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midrst_out_val", dif.out_val, 1'b0);
    checkOutput("midrst_rr_ptr", u_dut.u_arb.rr_ptr, 2'd0);
    checkOutput("midrst_in_rdy", dif.in_rdy, 4'h0);
    reset        = 1'b1;
    main_out_rdy = 1'b1;

    runNet("net_0_0", 0, 0, 20);
    runNet("net_3_10", 3, 10, 20);
    runNet("net_10_3", 10, 3, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
